// File: rtl/int_ctrl_if.sv
// Register-window bus between the system bridge and the interrupt controller.
// The bridge is the master: it drives the write strobe, address and data.
// The controller is the slave: it returns combinational read data.
interface int_ctrl_if;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/int_ctrl.sv
// Programmable interrupt controller feeding the CP0 HWInt input.
// Six raw lines are synchronised, then edge- or level-detected into PENDING.
// PENDING is masked by ENABLE to drive hw_int. Software reaches MODE, ENABLE,
// PENDING and CLAIM through a four-word window. int_ack from the CP0 wrapper
// latches the highest-priority active source into CLAIM and, for edge
// sources, optionally retires its pending bit.
module int_ctrl #(
    parameter int SYNC_STAGES = 2,   // legal range 2..3
    parameter bit AUTO_CLR    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] irq_in,
    int_ctrl_if.slave  bus,
    input  logic       int_ack,
    output logic [5:0] hw_int
);

    typedef enum logic [1:0] {
        REG_MODE    = 2'd0,
        REG_ENABLE  = 2'd1,
        REG_PENDING = 2'd2,
        REG_CLAIM   = 2'd3
    } reg_sel_e;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("int_ctrl: SYNC_STAGES must be 2 or 3");
    end

    logic [5:0] sync_q [SYNC_STAGES];
    logic [5:0] s;
    logic [5:0] s_prev;

    logic [5:0] mode;
    logic [5:0] enable;
    logic [5:0] pending;
    logic [5:0] pending_nxt;
    logic       claim_valid_q;
    logic [2:0] claim_id_q;

    logic [5:0] masked;
    logic       claim_valid;
    logic [2:0] claim_id;
    logic [5:0] auto_mask;
    logic [5:0] w1c_mask;
    logic [5:0] mode_chg;
    logic [5:0] rise;

    reg_sel_e   sel;
    logic       wr_mode;
    logic       wr_enable;
    logic       wr_pending;

    assign sel        = reg_sel_e'(bus.addr[3:2]);
    assign wr_mode    = bus.we && (sel == REG_MODE);
    assign wr_enable  = bus.we && (sel == REG_ENABLE);
    assign wr_pending = bus.we && (sel == REG_PENDING);

    // Synchroniser chain for the asynchronous lines, plus the previous-value flop.
    always_ff @(posedge clk) begin
        // NOTE: every stage of the chain is reset, not just the first, so a
        // line held high across reset is seen as a fresh rising edge.
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            s_prev <= '0;
        end else begin
            // NOTE: non-blocking assignments let each stage capture the value
            // its neighbour held before the edge, forming a true shift chain.
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_prev <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_prev;

    assign masked = pending & enable;
    assign hw_int = masked;

    // Priority pick of the claim candidate and the clear masks for this edge.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path through it can leave a value unassigned and infer a latch.
        claim_valid = |masked;
        claim_id    = 3'd0;
        auto_mask   = '0;
        w1c_mask    = '0;
        mode_chg    = '0;
        // Scanning upward lets the highest-numbered set bit win.
        for (int i = 0; i < 6; i++) begin
            if (masked[i]) begin
                claim_id = 3'(i);
            end
        end
        if (AUTO_CLR && int_ack && claim_valid) begin
            auto_mask = 6'(1) << claim_id;
        end
        if (wr_pending) begin
            w1c_mask = bus.wdata[5:0];
        end
        if (wr_mode) begin
            mode_chg = bus.wdata[5:0] ^ mode;
        end
    end

    // Next pending: edge bits set on a rise (set beats clear), level bits track s,
    // and any bit whose mode is being flipped is dropped.
    always_comb begin
        pending_nxt = ((mode & (rise | (pending & ~(w1c_mask | auto_mask))))
                      | (~mode & s)) & ~mode_chg;
    end

    // Pending state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Software-programmed MODE and ENABLE registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode   <= '0;
            enable <= '0;
        end else begin
            if (wr_mode) begin
                mode <= bus.wdata[5:0];
            end
            if (wr_enable) begin
                enable <= bus.wdata[5:0];
            end
        end
    end

    // CLAIM capture on interrupt entry; an empty candidate set records "none".
    always_ff @(posedge clk) begin
        if (reset) begin
            claim_valid_q <= 1'b0;
            claim_id_q    <= 3'd0;
        end else if (int_ack) begin
            claim_valid_q <= claim_valid;
            claim_id_q    <= claim_valid ? claim_id : 3'd0;
        end
    end

    // Combinational read mux over the register window.
    always_comb begin
        bus.rdata = '0;
        unique case (sel)
            REG_MODE:    bus.rdata = {26'd0, mode};
            REG_ENABLE:  bus.rdata = {26'd0, enable};
            REG_PENDING: bus.rdata = {26'd0, pending};
            REG_CLAIM:   bus.rdata = {claim_valid_q, 28'd0, claim_id_q};
            default:     bus.rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl. A behavioural model tracks the register
// file from the documented rules; every cycle the expected hw_int/rdata are
// pushed into a scoreboard and a separate monitor compares them at negedge.
module tb_int_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam bit AUTO_CLR    = 1'b1;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] irq_in;
    logic       int_ack;
    logic [5:0] hw_int;

    int_ctrl_if bus ();

    int_ctrl #(
        .SYNC_STAGES(SYNC_STAGES),
        .AUTO_CLR   (AUTO_CLR)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .irq_in (irq_in),
        .bus    (bus.slave),
        .int_ack(int_ack),
        .hw_int (hw_int)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [3:0]  addr;
        logic [5:0]  hw;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_n = 0;

    // Reference model state.
    logic [5:0] m_mode, m_en, m_pend;
    bit         m_cv;
    int         m_cid;
    logic [5:0] m_line[$];   // irq samples, oldest first; length SYNC_STAGES+1
    logic [5:0] cur_irq = '0;

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        case (a[3:2])
            2'd0:    return {26'd0, m_mode};
            2'd1:    return {26'd0, m_en};
            2'd2:    return {26'd0, m_pend};
            default: return m_cv ? (32'h8000_0000 | 32'(m_cid)) : 32'd0;
        endcase
    endfunction

    // Apply one clock edge to the model using the inputs the DUT sees now.
    task automatic model_edge();
        logic [5:0] sv, sp, np;
        int top;
        bit clr;
        if (reset) begin
            m_mode = '0; m_en = '0; m_pend = '0; m_cv = 0; m_cid = 0;
            m_line = {};
            for (int j = 0; j <= SYNC_STAGES; j++) m_line.push_back('0);
            return;
        end
        sv = m_line[1];
        sp = m_line[0];
        top = -1;
        for (int i = 5; i >= 0; i--) begin
            if (m_pend[i] && m_en[i]) begin
                top = i;
                break;
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (m_mode[i]) begin
                clr = (bus.we && bus.addr[3:2] == 2'd2 && bus.wdata[i])
                      || (AUTO_CLR && int_ack && top == i);
                if (sv[i] && !sp[i]) np[i] = 1'b1;
                else if (clr)        np[i] = 1'b0;
                else                 np[i] = m_pend[i];
            end else begin
                np[i] = sv[i];
            end
            if (bus.we && bus.addr[3:2] == 2'd0 && bus.wdata[i] != m_mode[i])
                np[i] = 1'b0;
        end
        if (int_ack) begin
            m_cv  = (top >= 0);
            m_cid = (top >= 0) ? top : 0;
        end
        if (bus.we && bus.addr[3:2] == 2'd0) m_mode = bus.wdata[5:0];
        if (bus.we && bus.addr[3:2] == 2'd1) m_en   = bus.wdata[5:0];
        m_pend = np;
        m_line.push_back(irq_in);
        void'(m_line.pop_front());
    endtask

    // One clock: advance the model on the edge, then drive new inputs and
    // queue what the DUT should show for the rest of this cycle.
    task automatic cyc(input logic [5:0] irq, input logic w, input logic [3:0] a,
                       input logic [31:0] d, input logic ack, input logic rst);
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        reset     = rst;
        irq_in    = irq;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        int_ack   = ack;
        e.cyc  = cyc_n;
        e.addr = a;
        e.hw   = m_pend & m_en;
        e.rd   = exp_rd(a);
        sb.push_back(e);
        cyc_n++;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) cyc(cur_irq, 1'b0, 4'(cyc_n * 4), 32'd0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cyc(cur_irq, 1'b1, a, d, 1'b0, 1'b0);
    endtask

    task automatic ack(input logic [3:0] read_addr);
        cyc(cur_irq, 1'b0, read_addr, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(cur_irq, 1'b0, 4'h0, 32'd0, 1'b0, 1'b1);
    endtask

    // Monitor: compare whatever expectation is outstanding for this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (hw_int !== e.hw) begin
                n_bad++;
                $display("FAIL hw_int cyc=%0d got=%02h exp=%02h", e.cyc, hw_int, e.hw);
            end
            n_cmp++;
            if (bus.rdata !== e.rd) begin
                n_bad++;
                $display("FAIL rdata cyc=%0d addr=%h got=%08h exp=%08h",
                         e.cyc, e.addr, bus.rdata, e.rd);
            end
        end
    end

    initial begin
        logic [5:0]  r_irq;
        logic        r_we, r_ack, r_rst;
        logic [3:0]  r_addr;
        logic [31:0] r_data;

        reset = 1'b1; irq_in = '0; int_ack = 1'b0;
        bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        do_reset(3);

        // Edge mode on all lines, only source 0 enabled; pulse, hold, W1C.
        wr(4'h0, 32'h3F); wr(4'h4, 32'h01);
        cur_irq = 6'h01; tick(3);
        cur_irq = 6'h00; tick(4);
        wr(4'h8, 32'h01); tick(3);

        // Level mode: track the line, W1C while high has no effect.
        wr(4'h0, 32'h00); wr(4'h4, 32'h3F);
        cur_irq = 6'h08; tick(4);
        wr(4'h8, 32'h08); tick(2);
        cur_irq = 6'h00; tick(4);

        // Edge sources 1 and 4 pending, three claims in a row.
        wr(4'h0, 32'h3F); wr(4'h4, 32'h12);
        cur_irq = 6'h12; tick(4);
        cur_irq = 6'h00; tick(3);
        ack(4'hC); tick(1); ack(4'hC); tick(1); ack(4'hC); tick(2);

        // Source 2 pending; W1C on the same edge as a new synchronised rise.
        wr(4'h4, 32'h3F);
        cur_irq = 6'h04; tick(4);
        cur_irq = 6'h00; tick(3);
        cur_irq = 6'h04; tick(2);
        wr(4'h8, 32'h04); tick(3);
        cur_irq = 6'h00; tick(2);

        // Mask everything, unmask, then flip the mode of a pending source.
        wr(4'h4, 32'h00); tick(4);
        wr(4'h4, 32'h3F); tick(2);
        wr(4'h0, 32'h3B); tick(4);

        // Reset mid-stream with line 5 held high, then reprogram edge mode.
        wr(4'h0, 32'h20);
        cur_irq = 6'h20; tick(4);
        do_reset(2);
        wr(4'h0, 32'h20); wr(4'h4, 32'h20); tick(5);
        cur_irq = 6'h00; tick(3);

        // Randomised traffic.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(3) == 0) cur_irq = cur_irq ^ 6'($urandom);
            r_irq  = cur_irq;
            r_we   = ($urandom_range(3) == 0);
            r_addr = 4'($urandom);
            if (r_we && r_addr[3:2] == 2'd0 && $urandom_range(3) != 0) r_addr[3:2] = 2'd2;
            r_data = $urandom;
            r_ack  = ($urandom_range(7) == 0);
            r_rst  = ($urandom_range(299) == 0);
            cyc(r_irq, r_we, r_addr, r_data, r_ack, r_rst);
        end
        tick(2);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain left=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
